// File: rtl/ram_responder.sv
// Word-addressed RAM slave with a programmable wait-state count, an out-of-range error response
// and restart/abort handling for requests that change or vanish while waiting.
module ram_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LAT         = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ramREN,
   input  logic        ramWEN,
   input  logic [31:0] ramaddr,
   input  logic [31:0] ramstore,
   output logic [31:0] ramload,
   output logic        ramwait,
   output logic [1:0]  ramstate
);

   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam logic [33:0] ADDR_END = 34'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  CNT_LAST = 4'(LAT > 0 ? LAT - 1 : 0);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BUSY   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_ERROR  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic          wr_q, wr_d;
   logic          req;
   logic          in_range;
   logic [AW-1:0] idx;
   logic [31:0]   mem [DEPTH_WORDS];

   assign req      = ramREN | ramWEN;
   assign in_range = {2'b00, ramaddr} < ADDR_END;
   assign idx      = addr_q[AW+1:2];
   assign ramstate = state_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d = ramaddr;
               wr_d   = ramWEN;
               cnt_d  = '0;
               if (!in_range)    state_d = S_ERROR;
               else if (LAT == 0) state_d = S_ACCESS;
               else               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!req) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (ramaddr != addr_q || ramWEN != wr_q) begin
               // Initiator changed its mind: start the wait over for the new request.
               addr_d  = ramaddr;
               wr_d    = ramWEN;
               cnt_d   = '0;
               state_d = in_range ? S_BUSY : S_ERROR;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_ACCESS;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      ramwait = 1'b0;
      ramload = '0;
      case (state_q)
         S_IDLE:   ramwait = req;
         S_BUSY:   ramwait = 1'b1;
         S_ACCESS: if (!wr_q) ramload = mem[idx];
         S_ERROR:  ramload = 32'hBAD1BAD1;
         default:  ramload = '0;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
      end
   end

   // Storage is deliberately not reset; reset only has to block an in-flight write.
   always_ff @(posedge CLK) begin
      if (state_q == S_ACCESS && wr_q && !RST) mem[idx] <= ramstore;
   end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: a LAT=2 and a LAT=0 instance driven by directed scenarios and random
// transactions, checked against a word-array model of the memory and the wait-time rule.
module tb_ram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        ren  [2];
   logic        wen  [2];
   logic [31:0] addr [2];
   logic [31:0] stor [2];
   logic [31:0] load [2];
   logic        wt   [2];
   logic [1:0]  st   [2];

   int          vectors     = 0;
   int          miscompares = 0;
   int          lat_of [2]  = '{2, 0};
   logic [31:0] mdl [2][1024];

   always #5 clk = ~clk;

   ram_responder #(.DEPTH_WORDS(1024), .LAT(2)) u_lat2 (
      .CLK(clk), .RST(rst), .ramREN(ren[0]), .ramWEN(wen[0]), .ramaddr(addr[0]),
      .ramstore(stor[0]), .ramload(load[0]), .ramwait(wt[0]), .ramstate(st[0]));

   ram_responder #(.DEPTH_WORDS(1024), .LAT(0)) u_lat0 (
      .CLK(clk), .RST(rst), .ramREN(ren[1]), .ramWEN(wen[1]), .ramaddr(addr[1]),
      .ramstore(stor[1]), .ramload(load[1]), .ramwait(wt[1]), .ramstate(st[1]));

   function automatic bit in_rng(input logic [31:0] a);
      return a < 32'h1000;
   endfunction

   // One complete request: returns number of wait-high cycles and outputs in the serviced cycle.
   task automatic xact(input int d, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] dat, input bit hold,
                       output int waits, output logic [31:0] ld, output logic [1:0] sv);
      @(posedge clk); #1;
      ren[d] = rd; wen[d] = wr; addr[d] = a; stor[d] = dat;
      waits = 0;
      forever begin
         @(negedge clk);
         if (!wt[d]) break;
         waits++;
         if (waits > 40) break;
      end
      ld = load[d];
      sv = st[d];
      if (!hold) begin
         @(posedge clk); #1;
         ren[d] = 1'b0; wen[d] = 1'b0;
      end
   endtask

   task automatic mwrite(input int d, input logic [31:0] a, input logic [31:0] dat);
      int w; logic [31:0] ld; logic [1:0] sv;
      xact(d, 1'b0, 1'b1, a, dat, 1'b0, w, ld, sv);
      mdl[d][a[11:2]] = dat;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (st[d] !== 2'd0) begin miscompares++; $display("FAIL reset_state[%0d]: got %0d expected 0", d, st[d]); end
         vectors++;
         if (wt[d] !== 1'b0) begin miscompares++; $display("FAIL reset_wait[%0d]: got %b expected 0", d, wt[d]); end
         vectors++;
         if (load[d] !== 32'h0) begin miscompares++; $display("FAIL reset_load[%0d]: got %h expected 0", d, load[d]); end
      end
      ren[0] = 1'b1;
      #1;
      vectors++;
      if (wt[0] !== 1'b1) begin miscompares++; $display("FAIL reset_wait_follows_req: got %b expected 1", wt[0]); end
      vectors++;
      if (st[0] !== 2'd0) begin miscompares++; $display("FAIL reset_state_held: got %0d expected 0", st[0]); end
      ren[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_lat2_rw();
      int w; logic [31:0] ld; logic [1:0] sv;
      xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, w, ld, sv);
      mdl[0][4] = 32'hDEADBEEF;
      vectors++;
      if (w !== 3) begin miscompares++; $display("FAIL lat2_write_waits: got %0d expected 3", w); end
      vectors++;
      if (ld !== 32'h0) begin miscompares++; $display("FAIL lat2_write_load: got %h expected 0", ld); end
      xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, w, ld, sv);
      vectors++;
      if (w !== 3) begin miscompares++; $display("FAIL lat2_read_waits: got %0d expected 3", w); end
      vectors++;
      if (sv !== 2'd2) begin miscompares++; $display("FAIL lat2_read_state: got %0d expected 2", sv); end
      vectors++;
      if (ld !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lat2_read_data: got %h expected deadbeef", ld); end
   endtask

   task automatic test_lat0_rw();
      int w; logic [31:0] ld; logic [1:0] sv;
      xact(1, 1'b0, 1'b1, 32'h4, 32'h12345678, 1'b0, w, ld, sv);
      mdl[1][1] = 32'h12345678;
      vectors++;
      if (w !== 1) begin miscompares++; $display("FAIL lat0_write_waits: got %0d expected 1", w); end
      xact(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, w, ld, sv);
      vectors++;
      if (w !== 1) begin miscompares++; $display("FAIL lat0_read_waits: got %0d expected 1", w); end
      vectors++;
      if (ld !== 32'h12345678) begin miscompares++; $display("FAIL lat0_read_data: got %h expected 12345678", ld); end
   endtask

   task automatic test_error();
      int w; logic [31:0] ld; logic [1:0] sv;
      mwrite(0, 32'h0, 32'h0BADF00D);
      xact(0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, w, ld, sv);
      vectors++;
      if (w !== 1) begin miscompares++; $display("FAIL err_read_waits: got %0d expected 1", w); end
      vectors++;
      if (sv !== 2'd3) begin miscompares++; $display("FAIL err_read_state: got %0d expected 3", sv); end
      vectors++;
      if (ld !== 32'hBAD1BAD1) begin miscompares++; $display("FAIL err_read_load: got %h expected bad1bad1", ld); end
      xact(0, 1'b0, 1'b1, 32'h1000, 32'hFFFF0000, 1'b0, w, ld, sv);
      vectors++;
      if (sv !== 2'd3) begin miscompares++; $display("FAIL err_write_state: got %0d expected 3", sv); end
      xact(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, w, ld, sv);
      vectors++;
      if (ld !== 32'h0BADF00D) begin miscompares++; $display("FAIL err_mem_unchanged: got %h expected 0badf00d", ld); end
   endtask

   task automatic test_restart();
      int w; logic [31:0] ld; logic [1:0] sv;
      mwrite(0, 32'h20, 32'h11111111);
      mwrite(0, 32'h24, 32'h22222222);
      @(posedge clk); #1;
      wen[0] = 1'b1; addr[0] = 32'h20; stor[0] = 32'hAAAA5555;
      @(negedge clk);
      w = wt[0] ? 1 : 0;
      @(posedge clk); #1;
      addr[0] = 32'h24;
      forever begin
         @(negedge clk);
         if (!wt[0] || w > 40) break;
         w++;
      end
      sv = st[0];
      @(posedge clk); #1;
      wen[0] = 1'b0;
      mdl[0][9] = 32'hAAAA5555;
      vectors++;
      if (w !== 4) begin miscompares++; $display("FAIL restart_waits: got %0d expected 4", w); end
      vectors++;
      if (sv !== 2'd2) begin miscompares++; $display("FAIL restart_state: got %0d expected 2", sv); end
      xact(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, w, ld, sv);
      vectors++;
      if (ld !== 32'h11111111) begin miscompares++; $display("FAIL restart_old_addr: got %h expected 11111111", ld); end
      xact(0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, w, ld, sv);
      vectors++;
      if (ld !== 32'hAAAA5555) begin miscompares++; $display("FAIL restart_new_addr: got %h expected aaaa5555", ld); end
   endtask

   task automatic test_drop();
      int w; logic [31:0] ld; logic [1:0] sv;
      mwrite(0, 32'h30, 32'h33333333);
      @(posedge clk); #1;
      wen[0] = 1'b1; addr[0] = 32'h30; stor[0] = 32'h44444444;
      @(posedge clk); #1;
      wen[0] = 1'b0;
      @(negedge clk);
      vectors++;
      if (st[0] !== 2'd1 || wt[0] !== 1'b1) begin miscompares++; $display("FAIL drop_busy: got state %0d wait %b expected 1 1", st[0], wt[0]); end
      @(negedge clk);
      vectors++;
      if (st[0] !== 2'd0 || wt[0] !== 1'b0) begin miscompares++; $display("FAIL drop_idle: got state %0d wait %b expected 0 0", st[0], wt[0]); end
      xact(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, w, ld, sv);
      vectors++;
      if (ld !== 32'h33333333) begin miscompares++; $display("FAIL drop_mem: got %h expected 33333333", ld); end
   endtask

   task automatic test_rst_mid();
      int w; logic [31:0] ld; logic [1:0] sv;
      mwrite(0, 32'h8, 32'h88888888);
      @(posedge clk); #1;
      wen[0] = 1'b1; addr[0] = 32'h8; stor[0] = 32'h99999999;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      vectors++;
      if (st[0] !== 2'd0 || load[0] !== 32'h0) begin miscompares++; $display("FAIL rst_busy_abort: got state %0d load %h expected 0 0", st[0], load[0]); end
      wen[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      xact(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, w, ld, sv);
      vectors++;
      if (ld !== 32'h88888888 || w !== 3) begin miscompares++; $display("FAIL rst_busy_mem: got %h/%0d expected 88888888/3", ld, w); end
      mwrite(1, 32'h8, 32'h77777777);
      @(posedge clk); #1;
      wen[1] = 1'b1; addr[1] = 32'h8; stor[1] = 32'h66666666;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (st[1] !== 2'd2) begin miscompares++; $display("FAIL rst_access_pre: got state %0d expected 2", st[1]); end
      #1;
      rst = 1'b1;
      #1;
      vectors++;
      if (st[1] !== 2'd0) begin miscompares++; $display("FAIL rst_access_abort: got state %0d expected 0", st[1]); end
      wen[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      xact(1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, w, ld, sv);
      vectors++;
      if (ld !== 32'h77777777) begin miscompares++; $display("FAIL rst_access_mem: got %h expected 77777777", ld); end
   endtask

   task automatic test_both();
      int w; logic [31:0] ld; logic [1:0] sv;
      for (int d = 0; d < 2; d++) begin
         xact(d, 1'b1, 1'b1, 32'hC, 32'h55, 1'b0, w, ld, sv);
         mdl[d][3] = 32'h55;
         vectors++;
         if (ld !== 32'h0 || sv !== 2'd2) begin miscompares++; $display("FAIL both_access[%0d]: got load %h state %0d expected 0 2", d, ld, sv); end
         xact(d, 1'b1, 1'b0, 32'hC, 32'h0, 1'b0, w, ld, sv);
         vectors++;
         if (ld !== 32'h55) begin miscompares++; $display("FAIL both_written[%0d]: got %h expected 55", d, ld); end
      end
   endtask

   task automatic test_back_to_back();
      int w; logic [31:0] ld; logic [1:0] sv;
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 2; k++) begin
            xact(d, 1'b1, 1'b0, 32'hC, 32'h0, (k == 0), w, ld, sv);
            vectors++;
            if (w !== lat_of[d] + 1 || ld !== 32'h55) begin
               miscompares++;
               $display("FAIL b2b[%0d][%0d]: got waits %0d load %h expected %0d 55", d, k, w, ld, lat_of[d] + 1);
            end
         end
      end
   endtask

   task automatic test_random();
      int w; logic [31:0] ld; logic [1:0] sv;
      int d, ew, op;
      bit hold, rd, wr;
      logic [31:0] a, dat, el;
      logic [1:0]  es;
      for (int dd = 0; dd < 2; dd++)
         for (int k = 0; k < 16; k++) mwrite(dd, 32'h100 + 32'(4 * k), $urandom);
      hold = 1'b0;
      d = 0;
      for (int n = 0; n < 150; n++) begin
         if (!hold) begin
            d = $urandom_range(0, 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
         end
         a = 32'h100 + 32'(4 * $urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) a = a | 32'h1000;
         else if ($urandom_range(0, 15) == 0) a = a | 32'h8000_0000;
         op  = $urandom_range(0, 2);
         rd  = (op != 1);
         wr  = (op != 0);
         dat = $urandom;
         hold = ($urandom_range(0, 3) == 0);
         ew = in_rng(a) ? lat_of[d] + 1 : 1;
         es = in_rng(a) ? 2'd2 : 2'd3;
         el = !in_rng(a) ? 32'hBAD1BAD1 : (wr ? 32'h0 : mdl[d][a[11:2]]);
         xact(d, rd, wr, a, dat, hold, w, ld, sv);
         if (wr && in_rng(a)) mdl[d][a[11:2]] = dat;
         vectors++;
         if (w !== ew || sv !== es || ld !== el) begin
            miscompares++;
            $display("FAIL rand[%0d] d%0d op%0d a=%h: got waits %0d state %0d load %h expected %0d %0d %h",
                     n, d, op, a, w, sv, ld, ew, es, el);
         end
      end
      @(posedge clk); #1;
      for (int dd = 0; dd < 2; dd++) begin ren[dd] = 1'b0; wen[dd] = 1'b0; end
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         ren[d] = 1'b0; wen[d] = 1'b0; addr[d] = '0; stor[d] = '0;
      end
      test_reset();
      test_lat2_rw();
      test_lat0_rw();
      test_error();
      test_restart();
      test_drop();
      test_rst_mid();
      test_both();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter LAT, default 2, meaning the number of BUSY wait cycles per access (0..15).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port ramREN, input, 1 bit: read request, held by the initiator until ramwait is low.
REQ-006 SHALL have port ramWEN, input, 1 bit: write request, held by the initiator until ramwait is low.
REQ-007 SHALL have port ramaddr, input, 32 bits: byte address; word index = ramaddr[log2(DEPTH_WORDS)+1:2], bits [1:0] ignored.
REQ-008 SHALL have port ramstore, input, 32 bits: write data.
REQ-009 SHALL have port ramload, output, 32 bits: read data, valid only in ACCESS or ERROR.
REQ-010 SHALL have port ramwait, output, 1 bit: high while a request is pending and not yet serviced.
REQ-011 SHALL have port ramstate, output, 2 bits: 0=IDLE, 1=BUSY, 2=ACCESS, 3=ERROR.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, ACCESS and ERROR, with a 4-bit wait counter.
REQ-013 IDLE: ramwait = ramREN|ramWEN (combinational); ramload = 0.
REQ-014 IDLE with a request and an in-range address SHALL go to BUSY with counter=0 if LAT>0, or directly to ACCESS if LAT=0; it SHALL latch ramaddr and the request type.
REQ-015 IDLE with a request and ramaddr >= 4*DEPTH_WORDS SHALL go to ERROR.
REQ-016 BUSY: ramwait=1; counter increments each cycle; when counter==LAT-1 the next state SHALL be ACCESS.
REQ-017 ACCESS: ramwait=0; for a read, ramload = mem[index]; for a write, mem[index] <= ramstore on the edge ending ACCESS; next state IDLE.
REQ-018 ERROR: ramwait=0; ramload=32'hBAD1BAD1; no memory write; next state IDLE.
REQ-019 Total read latency from first request cycle SHALL be LAT+2 cycles (e.g. LAT=2: wait high cycles 0-2, data valid cycle 3).
REQ-020 ramREN and ramWEN both high SHALL be treated as a write; ramload SHALL be 0 in that ACCESS.
REQ-021 Request dropped (both low) during BUSY SHALL return the FSM to IDLE next cycle with no memory change.
REQ-022 ramaddr or request type differing from the latched value during BUSY SHALL restart the access: relatch, counter=0, remain BUSY.
REQ-023 A request still high in the IDLE cycle after ACCESS SHALL start a new transaction (back-to-back accesses allowed, with no zero-wait repeat).
REQ-024 ramstate SHALL equal the encoding of the current state every cycle.

Reset
REQ-025 RST high SHALL immediately force IDLE, counter=0, latched address/type=0, ramload=0, ramstate=0; ramwait then follows REQ-013.
REQ-026 RST asserted mid-BUSY or mid-ACCESS SHALL abort the access; a pending write SHALL NOT occur.
REQ-027 Memory contents SHALL NOT be cleared by reset; reset deassertion SHALL take effect on the next CLK edge.

Verification
REQ-028 LAT=2: write 0x10 <= 0xDEADBEEF, then read 0x10 -> ramwait high 3 cycles, low in ACCESS, ramload=0xDEADBEEF.
REQ-029 LAT=0: read 0x4 after writing 0x12345678 -> ramwait high 1 cycle, ramload=0x12345678 in the next cycle.
REQ-030 Read address 0x1000 with DEPTH_WORDS=1024 -> ERROR after 1 cycle, ramload=0xBAD1BAD1, ramwait low, memory unchanged.
REQ-031 Write 0x20 <= 0xAAAA5555, change ramaddr to 0x24 in BUSY cycle 1 -> counter restarts, only 0x24 is written, 0x20 is unchanged.
REQ-032 RST pulse during BUSY of a write to 0x8 -> IDLE immediately, mem[0x8] keeps its old value, and a subsequent read returns the old value.
REQ-033 ramREN=ramWEN=1 to 0xC with 0x55 -> 0x55 is written, ramload=0 during ACCESS.
